// File: rtl/shift_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
//   Shared types and constants for the shift-register sequencing controller.
//   - state_e       : controller FSM states (IDLE, SHIFT, LATCH)
//   - NBITS_DEFAULT : default word length of the downstream shift register
//   - DIV_MAX       : largest bit-rate divider representable by the 8-bit
//                     divider counter
//   - clamp_div     : maps an elaboration-time DIV onto the legal range 1..255
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam int NBITS_DEFAULT = 8;
  localparam int DIV_MAX       = 255;

  // DIV=0 would never let the divider expire, so it is treated as 1. Values
  // above DIV_MAX cannot be loaded into the 8-bit divider and saturate there.
  function automatic int clamp_div(input int d);
    if (d < 1) begin
      return 1;
    end
    if (d > DIV_MAX) begin
      return DIV_MAX;
    end
    return d;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl_if
//   Requester handshake plus shift-register drive bundle of shift_seq_ctrl.
//   Signals:
//     req_valid[1:0]  per-requester valid (bit i = requester i)
//     req_data0/1     byte offered by requester 0/1, sampled on handshake
//     req_ready[1:0]  per-requester ready, one-hot or zero
//     abort           cancels an in-flight transfer
//     ser_data        serial bit to the shift-register data input
//     shift_en        one-cycle shift strobe
//     latch           one-cycle strobe when the full word is in place
//     busy            controller is not idle
//     done / done_id  completion pulse and the requester it belongs to
//   Modports:
//     master : requester / shift-register side (drives requests and abort)
//     slave  : the controller itself
// -----------------------------------------------------------------------------
interface shift_seq_ctrl_if
  import shift_ctrl_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
);

  logic [1:0]       req_valid;
  logic [NBITS-1:0] req_data0;
  logic [NBITS-1:0] req_data1;
  logic [1:0]       req_ready;
  logic             abort;
  logic             ser_data;
  logic             shift_en;
  logic             latch;
  logic             busy;
  logic             done;
  logic             done_id;

  modport master (
    output req_valid, req_data0, req_data1, abort,
    input  req_ready, ser_data, shift_en, latch, busy, done, done_id
  );

  modport slave (
    input  req_valid, req_data0, req_data1, abort,
    output req_ready, ser_data, shift_en, latch, busy, done, done_id
  );

endinterface

// File: rtl/shift_seq_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin arbiter, purely combinational. The caller owns the
//   last_grant register and updates it only when a grant is actually taken.
//   Ports:
//     req[1:0]    request vector
//     last_grant  index granted most recently
//     en          arbitration enable; no grant while low
//     gnt[1:0]    one-hot grant (zero when no grant)
//     gnt_idx     index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    if (en) begin
      case (req)
        2'b01: begin
          gnt     = 2'b01;
          gnt_idx = 1'b0;
        end
        2'b10: begin
          gnt     = 2'b10;
          gnt_idx = 1'b1;
        end
        2'b11: begin
          // Tie: the requester that was not served last goes first.
          gnt_idx = ~last_grant;
          gnt     = last_grant ? 2'b01 : 2'b10;
        end
        default: begin
          gnt     = 2'b00;
          gnt_idx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Sequencing controller for an NBITS-cell serial shift register. Arbitrates
//   between two requesters, shifts the granted word out MSB-first at one bit
//   every DIV clocks, then pulses latch/done for one cycle so downstream logic
//   samples the completed parallel word.
//   Parameters:
//     DIV    clk cycles per shifted bit (1..255; 0 is treated as 1)
//     NBITS  bits per transfer, equal to the shift-register length
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    shift_seq_ctrl_if.slave (requests, abort, shift-register drive)
// -----------------------------------------------------------------------------
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int DIV   = 1,
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_seq_ctrl_if.slave   bus
);

  localparam int             DIV_C      = clamp_div(DIV);
  localparam logic [7:0]     DIV_RELOAD = 8'(DIV_C - 1);
  localparam int             BCW        = $clog2(NBITS + 1);
  localparam logic [BCW-1:0] LAST_BIT   = BCW'(NBITS - 1);

  state_e           state_q,      state_d;
  logic             last_grant_q, last_grant_d;
  logic [NBITS-1:0] hold_q,       hold_d;
  logic             id_q,         id_d;
  logic [BCW-1:0]   bit_cnt_q,    bit_cnt_d;
  logic [7:0]       div_cnt_q,    div_cnt_d;

  logic [1:0]       gnt;
  logic             gnt_idx;
  logic             arb_en;
  logic             handshake;
  logic             tick;

  // Grants are only offered while idle. Holding them off during reset keeps
  // every output at zero for as long as rst_n is low.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arb2 u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign handshake = |(bus.req_valid & gnt);

  // Divider expiry: this is the cycle in which the register consumes the
  // current MSB. Abort does not suppress the strobe of the cycle it arrives
  // in; it only prevents any further ones.
  assign tick = (state_q == SHIFT) && (div_cnt_q == 8'd0);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;
    id_d         = id_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          hold_d       = gnt_idx ? bus.req_data1 : bus.req_data0;
          id_d         = gnt_idx;
          last_grant_d = gnt_idx;
          bit_cnt_d    = '0;
          div_cnt_d    = DIV_RELOAD;
          state_d      = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.abort) begin
          // Abort beats the final shift: the partial word is never latched.
          state_d = IDLE;
        end else if (tick) begin
          hold_d    = hold_q << 1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          div_cnt_d = DIV_RELOAD;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = LATCH;
          end
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end

      LATCH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      hold_q       <= '0;
      id_q         <= 1'b0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      id_q         <= id_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
    end
  end

  // Outputs decode registered state only (req_ready excepted), so they are
  // glitch-free relative to the shift register's capture edge.
  assign bus.req_ready = gnt;
  assign bus.ser_data  = (state_q == SHIFT) && hold_q[NBITS-1];
  assign bus.shift_en  = tick;
  assign bus.latch     = (state_q == LATCH);
  assign bus.done      = (state_q == LATCH);
  assign bus.done_id   = (state_q == LATCH) && id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;
  import shift_ctrl_pkg::*;

  localparam int NB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] valid = 2'b00;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic       abort = 1'b0;

  shift_seq_ctrl_if #(.NBITS(NB)) bus_a ();
  shift_seq_ctrl_if #(.NBITS(NB)) bus_b ();

  assign bus_a.req_valid = valid;
  assign bus_a.req_data0 = d0;
  assign bus_a.req_data1 = d1;
  assign bus_a.abort     = abort;
  assign bus_b.req_valid = valid;
  assign bus_b.req_data0 = d0;
  assign bus_b.req_data1 = d1;
  assign bus_b.abort     = abort;

  shift_seq_ctrl #(.DIV(1), .NBITS(NB)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  shift_seq_ctrl #(.DIV(4), .NBITS(NB)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // {req_ready[1:0], ser_data, shift_en, latch, busy, done, done_id}
  logic [7:0] obs [2];
  assign obs[0] = {bus_a.req_ready, bus_a.ser_data, bus_a.shift_en,
                   bus_a.latch, bus_a.busy, bus_a.done, bus_a.done_id};
  assign obs[1] = {bus_b.req_ready, bus_b.ser_data, bus_b.shift_en,
                   bus_b.latch, bus_b.busy, bus_b.done, bus_b.done_id};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int winner(input logic [1:0] v, input bit last);
    case (v)
      2'b01:   return 0;
      2'b10:   return 1;
      2'b11:   return last ? 0 : 1;
      default: return -1;
    endcase
  endfunction

  // Transaction-level reference: each accepted transfer is a timeline
  // measured in cycles since its handshake.
  bit         m_act  [2] = '{0, 0};
  int         m_n    [2] = '{0, 0};
  logic [7:0] m_byte [2] = '{8'h00, 8'h00};
  bit         m_id   [2] = '{0, 0};
  bit         m_last [2] = '{1, 1};
  logic [7:0] sr     [2] = '{8'h00, 8'h00};
  int         n_latch[2] = '{0, 0};
  bit         chk_on = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        int         dv;
        int         n;
        int         w;
        logic [1:0] er;
        logic       es, ee, el, eb, eid;
        dv  = (i == 0) ? 1 : 4;
        n   = m_n[i];
        w   = -1;
        er  = 2'b00;
        es  = 1'b0;
        ee  = 1'b0;
        el  = 1'b0;
        eb  = 1'b0;
        eid = 1'b0;
        if (m_act[i]) begin
          eb = 1'b1;
          if (n <= NB * dv) begin
            es = m_byte[i][NB - 1 - (n - 1) / dv];
            ee = ((n % dv) == 0);
          end else begin
            el  = 1'b1;
            eid = m_id[i];
          end
        end else if (rst_n) begin
          w = winner(valid, m_last[i]);
          if (w >= 0) er = 2'(1 << w);
        end
        chk($sformatf("outs%0d", i), {24'h0, obs[i]}, {24'h0, er, es, ee, el, eb, el, eid});

        if (obs[i][4] === 1'b1) sr[i] = {sr[i][6:0], obs[i][5]};
        if (el) begin
          chk($sformatf("word%0d", i), {24'h0, sr[i]}, {24'h0, m_byte[i]});
          n_latch[i]++;
        end

        if (!rst_n) begin
          m_act[i]  = 0;
          m_last[i] = 1;
        end else if (m_act[i]) begin
          if ((abort && n <= NB * dv) || n == NB * dv + 1) m_act[i] = 0;
          else m_n[i] = n + 1;
        end else if (w >= 0) begin
          m_act[i]  = 1;
          m_n[i]    = 1;
          m_byte[i] = (w == 1) ? d1 : d0;
          m_id[i]   = (w == 1);
          m_last[i] = (w == 1);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1;
    cyc();
    rst_n = 1'b1;

    // single A5 from requester 0
    valid = 2'b01;
    d0    = 8'hA5;
    cyc();
    valid = 2'b00;
    d0    = 8'($urandom);
    repeat (40) cyc();
    chk("lat_a_A5", n_latch[0], 1);
    chk("lat_b_A5", n_latch[1], 1);

    // both requesting continuously
    valid = 2'b11;
    d0    = 8'h0F;
    d1    = 8'hF0;
    repeat (100) cyc();
    valid = 2'b00;
    repeat (40) cyc();

    // lone requester 1
    valid = 2'b10;
    d1    = 8'h81;
    cyc();
    valid = 2'b00;
    repeat (40) cyc();

    // abort mid-transfer, then contention
    valid = 2'b01;
    d0    = 8'($urandom);
    cyc();
    valid = 2'b00;
    repeat ($urandom_range(0, 12)) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    valid = 2'b11;
    d0    = 8'($urandom);
    d1    = 8'($urandom);
    repeat (60) cyc();
    valid = 2'b00;
    repeat (40) cyc();

    // reset pulse mid-transfer
    valid = 2'b11;
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (60) cyc();
    valid = 2'b00;
    repeat (40) cyc();

    // short valid pulses while busy
    valid = 2'b01;
    cyc();
    valid = 2'b10;
    cyc();
    valid = 2'b00;
    repeat (40) cyc();

    // randomized traffic
    repeat (3000) begin
      valid = 2'($urandom);
      d0    = 8'($urandom);
      d1    = 8'($urandom);
      abort = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      cyc();
    end
    rst_n = 1'b1;
    abort = 1'b0;
    valid = 2'b00;
    repeat (40) cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencing controller for the 8-cell serial shift register. It arbitrates between two byte-wide requesters and serializes the granted byte MSB-first onto the register's serial input with a programmable bit rate. It then issues a one-cycle latch strobe so downstream logic samples the completed parallel word. It sits between the chip-level input decode and the shift register, and owns the register's data and shift-enable.

## Interface
- DIV, 1: clk cycles per shifted bit, legal range 1..255.
- NBITS, 8: bits per transfer; must match the shift-register length.

- clk  in  1  single system clock, all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester valid; bit i belongs to requester i.
- req_data0  in  8  byte from requester 0; sampled on handshake.
- req_data1  in  8  byte from requester 1; sampled on handshake.
- req_ready  out  2  per-requester ready, one-hot or zero.
- abort  in  1  cancels an in-flight transfer.
- ser_data  out  1  serial bit to the shift-register data input.
- shift_en  out  1  one-cycle shift strobe to the shift register.
- latch  out  1  one-cycle strobe when the full word is in place.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse, coincident with latch.
- done_id  out  1  requester index of the completed transfer; valid while done=1.

## Operation
- States: IDLE, SHIFT, LATCH.
- Reset: state=IDLE, last_grant=1, hold=0, bit_cnt=0, div_cnt=0. All outputs are 0.
- IDLE, arbitration:
  - req_ready[i] is combinational: 1 only for the arbiter's winner, and only in IDLE.
  - Round-robin: the requester not granted last wins on a tie. A lone valid always wins.
  - Handshake is valid&ready in the same cycle. On handshake: hold<=data, id<=winner, last_grant<=winner, bit_cnt<=0, div_cnt<=DIV-1, go to SHIFT.
- SHIFT:
  - ser_data = hold[NBITS-1] continuously.
  - div_cnt decrements each cycle. When div_cnt==0: shift_en=1, hold<=hold<<1, bit_cnt++, div_cnt<=DIV-1.
  - The shift_en that brings bit_cnt to NBITS moves the state to LATCH.
- LATCH: latch=1, done=1, done_id=id for one cycle, then IDLE.
- abort:
  - In SHIFT: next state is IDLE. No further shift_en, no latch, no done. last_grant is still updated.
  - In IDLE or LATCH: abort is ignored; LATCH always completes.
- ser_data is 0 outside SHIFT. req_data* is not re-sampled mid-transfer.
- Counters: bit_cnt is $clog2(NBITS+1) bits; div_cnt is 8 bits. DIV=0 is illegal and is clamped to 1 at elaboration.

## Timing
- Handshake in cycle T.
- shift_en in cycles T+k·DIV, for k=1..NBITS.
- latch/done in cycle T+NBITS·DIV+1.
- IDLE, with req_ready possibly asserted, in cycle T+NBITS·DIV+2.
- DIV=1, NBITS=8: handshake T, shift_en T+1..T+8, latch T+9, next handshake no earlier than T+10.
- ser_data holds the bit consumed by each shift_en in that same cycle. The register captures it on that edge.
- Requester back-to-back throughput: one byte per NBITS·DIV+2 cycles.
- rst_n low mid-transfer: outputs are 0 on the next edge, the partial word is discarded, and no latch is issued.
- abort and the final shift_en in the same cycle: abort wins. Go to IDLE with no latch.

## Structure
- Package shift_ctrl_pkg:
  - state enum {IDLE, SHIFT, LATCH}.
  - NBITS_DEFAULT=8, DIV_MAX=255.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: req[1:0], last_grant, en.
  - Outputs: one-hot gnt[1:0], gnt_idx.
  - Purely combinational. The last_grant register stays in the parent.
- The rest, FSM and counters in one always block plus output decode, is in shift_seq_ctrl.

## Test plan
- Reset, then req_valid=01, req_data0=0xA5, DIV=1:
  - Handshake at T; ser_data at the 8 shift_en cycles = 1,0,1,0,0,1,0,1.
  - latch=done=1 at T+9 with done_id=0; the shift register reads 0xA5.
- Both valid continuously, data0=0x0F, data1=0xF0:
  - Grants alternate 0,1,0,1, with the first grant to 0.
  - Each transfer latches its own byte; handshakes are 10 cycles apart.
- DIV=4, data1=0x81 alone:
  - shift_en at T+4, T+8, …, T+32; latch at T+33.
  - busy is high T+1..T+33; req_ready stays 0 throughout.
- abort asserted on the 3rd shift_en cycle:
  - No further shift_en, no latch, no done; IDLE the next cycle.
  - The next grant goes to the other requester.
- rst_n low for 1 cycle mid-SHIFT:
  - All outputs 0 the next cycle.
  - After release, requester 0 wins first; no latch from the discarded transfer.
- Valid dropped before grant (valid=1 for one cycle during busy, then 0):
  - No handshake, no spurious transfer; controller stays in IDLE.
